// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter with overflow flag and leading-zero blank mask.
// Latency: oDONE is high in the 21st cycle after the edge that accepts iSTART (BIN_W+1 busy cycles in total).
// Backpressure: none; iSTART is taken only when idle, and starts seen while oBUSY is high are dropped.
module bin2bcd_seq #(
  parameter int BIN_W   = 20,
  parameter int NUM_DIG = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iSTART,
  input  logic [BIN_W-1:0]     iBIN,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic [4*NUM_DIG-1:0] oBCD,
  output logic                 oOVF,
  output logic [NUM_DIG-1:0]   oBLANK
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int BCD_W = 4 * NUM_DIG;
  localparam longint unsigned LIMIT = pow10(NUM_DIG);
  localparam int LIMIT_BITS = $clog2(LIMIT) + 1;
  // Compare wide enough to hold both the input and 10^NUM_DIG.
  localparam int CMP_W = (BIN_W > LIMIT_BITS) ? BIN_W : LIMIT_BITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [NUM_DIG-1:0] BLANK_RST = {{(NUM_DIG-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             stateNext;
  logic [BIN_W-1:0]   shiftReg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratchNext;
  logic [CNT_W-1:0]   bitCnt;
  logic               ovfNext;
  logic               startOvf;
  logic               lastShift;
  logic [CMP_W-1:0]   binExt;
  logic [NUM_DIG-1:0] blankNext;
  logic               zeroRun;

  assign binExt    = CMP_W'(iBIN);
  assign startOvf  = (binExt >= CMP_W'(LIMIT));
  assign lastShift = (state == SHIFT) && (bitCnt == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and handshake outputs, decoded only from state so inputs never reach outputs.
  always_comb begin
    stateNext = state;
    oBUSY     = 1'b0;
    oDONE     = 1'b0;
    case (state)
      IDLE:  if (iSTART) stateNext = SHIFT;
      SHIFT: begin
        oBUSY = 1'b1;
        if (bitCnt == CNT_W'(1)) stateNext = DONE;
      end
      DONE: begin
        oBUSY     = 1'b1;
        oDONE     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  // The carry out of the top digit falls off, which yields iBIN mod 10^NUM_DIG.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < NUM_DIG; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    scratchNext = (adj << 1) | BCD_W'(shiftReg[BIN_W-1]);
  end

  // Leading-zero mask of the finished result; the units digit is never blanked.
  always_comb begin
    blankNext = '0;
    zeroRun   = 1'b1;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      zeroRun      = zeroRun & (scratchNext[4*i +: 4] == 4'd0);
      blankNext[i] = zeroRun;
    end
  end

  // Conversion datapath: load on accepted start, step once per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg <= '0;
      scratch  <= '0;
      bitCnt   <= '0;
      ovfNext  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            shiftReg <= iBIN;
            scratch  <= '0;
            bitCnt   <= CNT_W'(BIN_W);
            ovfNext  <= startOvf;
          end
        end
        SHIFT: begin
          scratch  <= scratchNext;
          shiftReg <= shiftReg << 1;
          bitCnt   <= bitCnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final shift so they are already valid while oDONE is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oBCD   <= '0;
      oOVF   <= 1'b0;
      oBLANK <= BLANK_RST;
    end else if (lastShift) begin
      oBCD   <= scratchNext;
      oOVF   <= ovfNext;
      oBLANK <= blankNext;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic (div/mod) reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iSTART = 1'b0;
  logic [19:0] iBIN = '0;
  logic        oBUSY;
  logic        oDONE;
  logic [23:0] oBCD;
  logic        oOVF;
  logic [5:0]  oBLANK;

  int nVec = 0;
  int nErr = 0;

  bin2bcd_seq #(.BIN_W(20), .NUM_DIG(6)) dut (
    .clk(clk), .rst_n(rst_n), .iSTART(iSTART), .iBIN(iBIN),
    .oBUSY(oBUSY), .oDONE(oDONE), .oBCD(oBCD), .oOVF(oOVF), .oBLANK(oBLANK)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits of v mod 10^6.
  function automatic logic [23:0] modelBcd(input int unsigned v);
    int unsigned r;
    logic [23:0] b;
    r = v % 1000000;
    b = '0;
    for (int d = 0; d < 6; d++) begin
      b[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  // Digits i..5 are all zero exactly when the residue is below 10^i.
  function automatic logic [5:0] modelBlank(input int unsigned v);
    int unsigned r;
    int unsigned p;
    logic [5:0] bl;
    r = v % 1000000;
    p = 10;
    bl = '0;
    for (int i = 1; i < 6; i++) begin
      bl[i] = (r < p);
      p = p * 10;
    end
    return bl;
  endfunction

  function automatic logic modelOvf(input int unsigned v);
    return v >= 1000000;
  endfunction

  // Drives one conversion from an idle #1-after-edge point; returns at the first idle sample.
  task automatic runConv(input int unsigned v, output int doneAt, output int busyN, output int doneN,
                         output logic [23:0] bcdD, output logic ovfD, output logic [5:0] blankD);
    doneAt = -1; busyN = 0; doneN = 0; bcdD = 'x; ovfD = 1'bx; blankD = 'x;
    iSTART = 1'b1;
    iBIN   = 20'(v);
    @(posedge clk); #1;
    iSTART = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!oBUSY) break;
      iBIN = 20'($urandom);
      busyN++;
      if (oDONE) begin
        doneN++;
        doneAt = c;
        bcdD   = oBCD;
        ovfD   = oOVF;
        blankD = oBLANK;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iSTART = 1'b0;
    #12;
    nVec++; if (oBUSY !== 1'b0) begin nErr++; $display("FAIL reset_busy got %b exp 0", oBUSY); end
    nVec++; if (oDONE !== 1'b0) begin nErr++; $display("FAIL reset_done got %b exp 0", oDONE); end
    nVec++; if (oOVF !== 1'b0) begin nErr++; $display("FAIL reset_ovf got %b exp 0", oOVF); end
    nVec++; if (oBCD !== 24'h000000) begin nErr++; $display("FAIL reset_bcd got %h exp 000000", oBCD); end
    nVec++; if (oBLANK !== 6'b111110) begin nErr++; $display("FAIL reset_blank got %b exp 111110", oBLANK); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int unsigned vals [6] = '{0, 123456, 42, 999999, 1000000, 1048575};
    int doneAt, busyN, doneN;
    logic [23:0] bcdD;
    logic ovfD;
    logic [5:0] blankD;
    foreach (vals[k]) begin
      runConv(vals[k], doneAt, busyN, doneN, bcdD, ovfD, blankD);
      nVec++; if (doneAt !== 21) begin nErr++; $display("FAIL dir_latency v=%0d got %0d exp 21", vals[k], doneAt); end
      nVec++; if (busyN !== 21) begin nErr++; $display("FAIL dir_busy v=%0d got %0d exp 21", vals[k], busyN); end
      nVec++; if (doneN !== 1) begin nErr++; $display("FAIL dir_donecount v=%0d got %0d exp 1", vals[k], doneN); end
      nVec++; if (bcdD !== modelBcd(vals[k])) begin nErr++; $display("FAIL dir_bcd v=%0d got %h exp %h", vals[k], bcdD, modelBcd(vals[k])); end
      nVec++; if (ovfD !== modelOvf(vals[k])) begin nErr++; $display("FAIL dir_ovf v=%0d got %b exp %b", vals[k], ovfD, modelOvf(vals[k])); end
      nVec++; if (blankD !== modelBlank(vals[k])) begin nErr++; $display("FAIL dir_blank v=%0d got %b exp %b", vals[k], blankD, modelBlank(vals[k])); end
      nVec++; if (oBCD !== modelBcd(vals[k])) begin nErr++; $display("FAIL dir_hold v=%0d got %h exp %h", vals[k], oBCD, modelBcd(vals[k])); end
    end
  endtask

  // Previous result is 1048575; a start pulse in cycle 5 must not disturb or restart the run.
  task automatic test_ignore_start();
    int early = 0, doneN = 0, extra = 0;
    logic [23:0] bcdD = 'x;
    iSTART = 1'b1; iBIN = 20'd123456;
    @(posedge clk); #1;
    iSTART = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!oBUSY) break;
      if (c == 5) begin iSTART = 1'b1; iBIN = 20'd7; end
      else iSTART = 1'b0;
      if (oDONE) begin doneN++; bcdD = oBCD; end
      else if (oBCD !== modelBcd(1048575)) early++;
      @(posedge clk); #1;
    end
    iSTART = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (oBUSY || oDONE) extra++;
      @(posedge clk); #1;
    end
    nVec++; if (early !== 0) begin nErr++; $display("FAIL ign_early_update got %0d cycles exp 0", early); end
    nVec++; if (doneN !== 1) begin nErr++; $display("FAIL ign_donecount got %0d exp 1", doneN); end
    nVec++; if (bcdD !== 24'h123456) begin nErr++; $display("FAIL ign_bcd got %h exp 123456", bcdD); end
    nVec++; if (extra !== 0) begin nErr++; $display("FAIL ign_restart got %0d busy cycles exp 0", extra); end
  endtask

  task automatic test_reset_midflight();
    int extra = 0;
    int doneAt, busyN, doneN;
    logic [23:0] bcdD;
    logic ovfD;
    logic [5:0] blankD;
    iSTART = 1'b1; iBIN = 20'd555555;
    @(posedge clk); #1;
    iSTART = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    nVec++; if (oBUSY !== 1'b1) begin nErr++; $display("FAIL rst_pre_busy got %b exp 1", oBUSY); end
    rst_n = 1'b0;
    #1;
    nVec++; if (oBUSY !== 1'b0) begin nErr++; $display("FAIL rst_busy got %b exp 0", oBUSY); end
    nVec++; if (oDONE !== 1'b0) begin nErr++; $display("FAIL rst_done got %b exp 0", oDONE); end
    nVec++; if (oBCD !== 24'h000000) begin nErr++; $display("FAIL rst_bcd got %h exp 000000", oBCD); end
    nVec++; if (oOVF !== 1'b0) begin nErr++; $display("FAIL rst_ovf got %b exp 0", oOVF); end
    nVec++; if (oBLANK !== 6'b111110) begin nErr++; $display("FAIL rst_blank got %b exp 111110", oBLANK); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (oBUSY || oDONE) extra++;
      @(posedge clk); #1;
    end
    nVec++; if (extra !== 0) begin nErr++; $display("FAIL rst_stale_run got %0d busy cycles exp 0", extra); end
    runConv(987654, doneAt, busyN, doneN, bcdD, ovfD, blankD);
    nVec++; if (bcdD !== 24'h987654) begin nErr++; $display("FAIL rst_fresh_bcd got %h exp 987654", bcdD); end
    nVec++; if (doneAt !== 21) begin nErr++; $display("FAIL rst_fresh_latency got %0d exp 21", doneAt); end
  endtask

  // iSTART held high: result every BIN_W+2 = 22 cycles.
  task automatic test_back_to_back();
    int doneCycles[$];
    int badBcd = 0;
    iSTART = 1'b1; iBIN = 20'd314159;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (oDONE) begin
        doneCycles.push_back(c);
        if (oBCD !== 24'h314159) badBcd++;
      end
    end
    iSTART = 1'b0;
    for (int c = 0; c < 40 && oBUSY; c++) begin @(posedge clk); #1; end
    nVec++; if (doneCycles.size() !== 5) begin nErr++; $display("FAIL b2b_count got %0d exp 5", doneCycles.size()); end
    nVec++; if (badBcd !== 0) begin nErr++; $display("FAIL b2b_bcd got %0d bad results exp 0", badBcd); end
    if (doneCycles.size() > 0) begin
      nVec++; if (doneCycles[0] !== 21) begin nErr++; $display("FAIL b2b_first got %0d exp 21", doneCycles[0]); end
    end
    for (int k = 1; k < doneCycles.size(); k++) begin
      nVec++;
      if (doneCycles[k] - doneCycles[k-1] !== 22) begin
        nErr++; $display("FAIL b2b_gap idx=%0d got %0d exp 22", k, doneCycles[k] - doneCycles[k-1]);
      end
    end
    nVec++; if (oBUSY !== 1'b0) begin nErr++; $display("FAIL b2b_idle got %b exp 0", oBUSY); end
  endtask

  task automatic test_random();
    int unsigned v;
    int doneAt, busyN, doneN;
    logic [23:0] bcdD;
    logic ovfD;
    logic [5:0] blankD;
    for (int n = 0; n < 1000; n++) begin
      if (n % 4 == 0) v = $urandom_range(1000009, 999990);
      else            v = $urandom_range(1048575, 0);
      runConv(v, doneAt, busyN, doneN, bcdD, ovfD, blankD);
      nVec++; if (doneN !== 1) begin nErr++; $display("FAIL rnd_done v=%0d got %0d exp 1", v, doneN); end
      nVec++; if (bcdD !== modelBcd(v)) begin nErr++; $display("FAIL rnd_bcd v=%0d got %h exp %h", v, bcdD, modelBcd(v)); end
      nVec++; if (ovfD !== modelOvf(v)) begin nErr++; $display("FAIL rnd_ovf v=%0d got %b exp %b", v, ovfD, modelOvf(v)); end
      nVec++; if (blankD !== modelBlank(v)) begin nErr++; $display("FAIL rnd_blank v=%0d got %b exp %b", v, blankD, modelBlank(v)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
